// File: rtl/seg_pkg.sv
// Package seg_pkg: shared constants, scan-state type and the leading-zero
// eligibility helper for the seg_scan_mux display scanner.
//   DIGITS     : number of display digits
//   NIBBLE_W   : bits per hex digit
//   ANODE_OFF  : active-low anode pattern with every digit dark
//   lz_mask()  : per-digit "may be lit" mask for leading-zero blanking
package seg_pkg;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned NIBBLE_W  = 4;
    localparam logic [3:0]  ANODE_OFF = 4'b1111;

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;

    // Digit i is eligible when any nibble at or above i is non-zero; digit 0
    // is always eligible so an all-zero value still shows a single "0".
    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        logic [3:0] m;
        m[0] = 1'b1;
        m[1] = |v[15:4];
        m[2] = |v[15:8];
        m[3] = |v[15:12];
        return m;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: slot counter and digit index for the display scan.
// Ports:
//   clk_i        : system clock, rising edge
//   reset_ni     : synchronous active-low reset
//   digit_idx_o  : current slot index 0..3
//   slot_end_o   : high on the last cycle of every slot
//   frame_end_o  : high on the last cycle of slot 3
//   in_blank_o   : high while the slot is in its anti-ghost blanking window
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    output logic [1:0] digit_idx_o,
    output logic       slot_end_o,
    output logic       frame_end_o,
    output logic       in_blank_o
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CntW-1:0] count_q, count_d;
    logic [1:0]      idx_q, idx_d;
    scan_state_t     state_q, state_d;
    logic            slot_end;

    always_comb begin
        slot_end = (count_q == CntW'(REFRESH_DIV - 1));
        count_d  = slot_end ? '0 : count_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        // State tracks the count it will hold next, so it is aligned with count_q.
        state_d  = (count_d < CntW'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= '0;
            idx_q   <= 2'd0;
            state_q <= ST_BLANK;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign digit_idx_o = idx_q;
    assign slot_end_o  = slot_end;
    assign frame_end_o = slot_end && (idx_q == 2'd3);
    assign in_blank_o  = (state_q == ST_BLANK);

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes a 16-bit hex value onto a 4-digit
// common-segment display, with a frame-synchronised shadow load so the
// displayed digits never tear.
// Ports:
//   clk        : system clock, rising edge
//   reset_L    : synchronous active-low reset
//   load       : 1-cycle strobe, capture data_in into the shadow register
//   data_in    : value to show, [3:0] = rightmost digit
//   digit_en   : per-digit enable, 0 keeps that anode off
//   nibble     : hex nibble of the current digit (registered)
//   anode_L    : active-low anodes, bit3 = leftmost (registered)
//   digit_idx  : current slot index 0..3
//   pending    : shadow loaded but not yet committed to display
//   frame_done : 1-cycle pulse on the last cycle of the digit-3 slot
// Build option: define SEG_LZ_BLANK_EN to enable leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  nibble,
    output logic [3:0]  anode_L,
    output logic [1:0]  digit_idx,
    output logic        pending,
    output logic        frame_done
);

    logic        frame_end;
    logic        slot_end;
    logic        in_blank;
    logic [1:0]  idx;

    logic [15:0] shadow_q, disp_q;
    logic        pending_q;
    logic [3:0]  anode_q, anode_d;
    logic [3:0]  nibble_q, nibble_d;
    logic [3:0]  show_mask;

    seg_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_i       (clk),
        .reset_ni    (reset_L),
        .digit_idx_o (idx),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end),
        .in_blank_o  (in_blank)
    );

    always_comb begin
`ifdef SEG_LZ_BLANK_EN
        show_mask = digit_en & lz_mask(disp_q);
`else
        show_mask = digit_en;
`endif
        nibble_d = disp_q[NIBBLE_W*idx +: NIBBLE_W];
        anode_d  = ANODE_OFF;
        if (!in_blank) begin
            anode_d[idx] = ~show_mask[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            shadow_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            pending_q <= 1'b0;
            anode_q   <= ANODE_OFF;
            nibble_q  <= 4'h0;
        end else begin
            if (load) begin
                shadow_q <= data_in;
            end
            // Commit uses the shadow value from before this cycle, so a load on
            // the boundary lands in the shadow and waits for the next frame.
            if (frame_end && pending_q) begin
                disp_q <= shadow_q;
            end
            if (load) begin
                pending_q <= 1'b1;
            end else if (frame_end) begin
                pending_q <= 1'b0;
            end
            anode_q  <= anode_d;
            nibble_q <= nibble_d;
        end
    end

    assign nibble     = nibble_q;
    assign anode_L    = anode_q;
    assign digit_idx  = idx;
    assign pending    = pending_q;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
// cyc counts rising edges since reset release; state during cyc k has
// count = k%8, slot = (k/8)%4; anode_L/nibble at cyc k reflect cyc k-1.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  digit_en;
    logic [3:0]  nibble;
    logic [3:0]  anode_L;
    logic [1:0]  digit_idx;
    logic        pending;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    seg_scan_mux #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .load       (load),
        .data_in    (data_in),
        .digit_en   (digit_en),
        .nibble     (nibble),
        .anode_L    (anode_L),
        .digit_idx  (digit_idx),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        load    = 1'b1;
        data_in = v;
        tick();
        load    = 1'b0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        repeat (3) tick();
        check_eq("rst_anode", 16'(anode_L), 16'hF);
        check_eq("rst_nibble", 16'(nibble), 16'h0);
        check_eq("rst_pending", 16'(pending), 16'h0);
        check_eq("rst_frame_done", 16'(frame_done), 16'h0);
        check_eq("rst_idx", 16'(digit_idx), 16'h0);
        reset_L = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        reset_L  = 1'b0;
        load     = 1'b0;
        data_in  = 16'h0;
        digit_en = 4'b1111;

        // 1. reset
        do_reset();

        // 2. load then display
        wait_to(5);
        do_load(16'h1234);
        check_eq("t2_pending_set", 16'(pending), 16'h1);
        wait_to(30);
        check_eq("t2_fd_early", 16'(frame_done), 16'h0);
        tick();
        check_eq("t2_fd_boundary", 16'(frame_done), 16'h1);
        check_eq("t2_pending_hold", 16'(pending), 16'h1);
        tick();
        check_eq("t2_pending_clr", 16'(pending), 16'h0);
        check_eq("t2_fd_after", 16'(frame_done), 16'h0);
        wait_to(33);
        check_eq("t2_s0_blank_anode", 16'(anode_L), 16'hF);
        check_eq("t2_s0_blank_nib", 16'(nibble), 16'h4);
        wait_to(35);
        check_eq("t2_s0_anode", 16'(anode_L), 16'hE);
        check_eq("t2_s0_nib", 16'(nibble), 16'h4);
        wait_to(40);
        check_eq("t2_s0_last_anode", 16'(anode_L), 16'hE);
        wait_to(41);
        check_eq("t2_s1_blank_anode", 16'(anode_L), 16'hF);
        check_eq("t2_s1_nib", 16'(nibble), 16'h3);
        wait_to(43);
        check_eq("t2_s1_anode", 16'(anode_L), 16'hD);
        wait_to(59);
        check_eq("t2_s3_anode", 16'(anode_L), 16'h7);
        check_eq("t2_s3_nib", 16'(nibble), 16'h1);
        check_eq("t2_s3_idx", 16'(digit_idx), 16'h3);

        // 3. last load wins
        wait_to(66);
        do_load(16'hAAAA);
        check_eq("t3_pending", 16'(pending), 16'h1);
        wait_to(70);
        do_load(16'h00F0);
        wait_to(90);
        check_eq("t3_old_still_shown", 16'(nibble), 16'h1);
        wait_to(97);
        check_eq("t3_d0", 16'(nibble), 16'h0);
        wait_to(105);
        check_eq("t3_d1", 16'(nibble), 16'hF);
        wait_to(113);
        check_eq("t3_d2", 16'(nibble), 16'h0);
        wait_to(121);
        check_eq("t3_d3", 16'(nibble), 16'h0);

        // 4. load on the boundary with a value already pending
        wait_to(100);
        do_load(16'h1111);
        wait_to(127);
        check_eq("t4_fd", 16'(frame_done), 16'h1);
        do_load(16'h5555);
        check_eq("t4_pending_kept", 16'(pending), 16'h1);
        wait_to(129);
        check_eq("t4_first_frame", 16'(nibble), 16'h1);
        wait_to(145);
        check_eq("t4_first_frame_d2", 16'(nibble), 16'h1);
        wait_to(160);
        check_eq("t4_pending_clr", 16'(pending), 16'h0);
        digit_en = 4'b0101;
        wait_to(161);
        check_eq("t4_second_frame", 16'(nibble), 16'h5);

        // 5. digit mask, then reset in slot-2 show
        wait_to(163);
        check_eq("t5_s0_anode", 16'(anode_L), 16'hE);
        wait_to(171);
        check_eq("t5_s1_masked", 16'(anode_L), 16'hF);
        wait_to(179);
        check_eq("t5_s2_anode", 16'(anode_L), 16'hB);
        wait_to(187);
        check_eq("t5_s3_masked", 16'(anode_L), 16'hF);
        wait_to(205);
        do_load(16'h9876);
        wait_to(211);
        check_eq("t5_pre_rst_anode", 16'(anode_L), 16'hB);
        check_eq("t5_pre_rst_pending", 16'(pending), 16'h1);
        reset_L = 1'b0;
        tick();
        check_eq("t5_rst_anode", 16'(anode_L), 16'hF);
        check_eq("t5_rst_idx", 16'(digit_idx), 16'h0);
        check_eq("t5_rst_pending", 16'(pending), 16'h0);
        check_eq("t5_rst_nibble", 16'(nibble), 16'h0);
        digit_en = 4'b1111;
        do_reset();

        // 6. leading zeros: blanked with SEG_LZ_BLANK_EN, shown otherwise
        wait_to(2);
        do_load(16'h00F0);
        wait_to(35);
        check_eq("t6_f0_d0", 16'(anode_L), 16'hE);
        wait_to(40);
        do_load(16'h0000);
        wait_to(43);
        check_eq("t6_f0_d1", 16'(anode_L), 16'hD);
`ifdef SEG_LZ_BLANK_EN
        wait_to(51);
        check_eq("t6_f0_d2", 16'(anode_L), 16'hF);
        wait_to(59);
        check_eq("t6_f0_d3", 16'(anode_L), 16'hF);
        wait_to(67);
        check_eq("t6_z_d0", 16'(anode_L), 16'hE);
        wait_to(75);
        check_eq("t6_z_d1", 16'(anode_L), 16'hF);
        wait_to(83);
        check_eq("t6_z_d2", 16'(anode_L), 16'hF);
        wait_to(91);
        check_eq("t6_z_d3", 16'(anode_L), 16'hF);
`else
        wait_to(51);
        check_eq("t6_f0_d2", 16'(anode_L), 16'hB);
        wait_to(59);
        check_eq("t6_f0_d3", 16'(anode_L), 16'h7);
        wait_to(67);
        check_eq("t6_z_d0", 16'(anode_L), 16'hE);
        wait_to(75);
        check_eq("t6_z_d1", 16'(anode_L), 16'hD);
        wait_to(83);
        check_eq("t6_z_d2", 16'(anode_L), 16'hB);
        wait_to(91);
        check_eq("t6_z_d3", 16'(anode_L), 16'h7);
`endif
        check_eq("t6_z_nib", 16'(nibble), 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
